// File: rtl/kernel_filter_3x3.sv
// kernel_filter_3x3: raster-order 3x3 Gaussian filter (1 2 1 / 2 4 2 / 1 2 1) with two line buffers.
// Define KERNEL_BYPASS_EN to add a per-frame bypass input that passes the center pixel through unfiltered.
module kernel_filter_3x3 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       in_valid,
    input  logic       in_sof,
`ifdef KERNEL_BYPASS_EN
    input  logic       bypass,
`endif
    output logic [7:0] pix_out,
    output logic       out_valid,
    output logic       out_sof,
    output logic       frame_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RMAX = RW'(HEIGHT - 1);
    localparam logic [CW:0] PRIME = (CW + 1)'(WIDTH + 1);

    logic [CW-1:0] col, c_eff, cc;
    logic [RW-1:0] row, r_eff, cr;
    logic [CW:0] prime_cnt;
    logic started, acc, trig, border, pass;
    logic v1, sof1, pass1;
    logic [7:0] lb0 [WIDTH];
    logic [7:0] lb1 [WIDTH];
    logic [7:0] w [3][3];
    logic [11:0] sum, edges;
    logic [7:0] filt;

    // nothing is accepted after reset until a frame start arrives
    assign acc   = in_valid && (started || in_sof);
    assign trig  = acc && prime_cnt == PRIME;
    assign c_eff = in_sof ? '0 : col;
    assign r_eff = in_sof ? '0 : row;

    // center trails the accepted pixel by one line plus one pixel, wrapping across frames
    assign cc = c_eff == '0 ? CMAX : c_eff - CW'(1);
    assign cr = c_eff == '0 ? (r_eff == '0 ? RMAX - RW'(1) : r_eff == RW'(1) ? RMAX : r_eff - RW'(2))
                            : (r_eff == '0 ? RMAX : r_eff - RW'(1));
    assign border = cr == '0 || cr == RMAX || cc == '0 || cc == CMAX;

    assign edges = 12'(w[0][1]) + 12'(w[1][0]) + 12'(w[1][2]) + 12'(w[2][1]);
    assign sum   = 12'(w[0][0]) + 12'(w[0][2]) + 12'(w[2][0]) + 12'(w[2][2]) + (edges << 1) + (12'(w[1][1]) << 2);
    assign filt  = 8'((sum + 12'd8) >> 4);

`ifdef KERNEL_BYPASS_EN
    logic byp_cur, byp_prev, center_prev;
    // tail centers of the previous frame keep that frame's bypass setting
    assign center_prev = r_eff == '0 || (r_eff == RW'(1) && c_eff == '0);
    assign pass = border || ((center_prev && !in_sof) ? byp_prev : byp_cur);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_cur  <= 1'b0;
            byp_prev <= 1'b0;
        end else if (acc && in_sof) begin
            byp_prev <= byp_cur;
            byp_cur  <= bypass;
        end
    end
`else
    assign pass = border;
`endif

    // line buffers and window hold data only; stale contents are masked by priming
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[c_eff] <= pix_in;
            lb1[c_eff] <= lb0[c_eff];
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
            w[0][2] <= lb1[c_eff];
            w[1][2] <= lb0[c_eff];
            w[2][2] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            started   <= 1'b0;
            prime_cnt <= '0;
            frame_err <= 1'b0;
            v1        <= 1'b0;
            sof1      <= 1'b0;
            pass1     <= 1'b0;
            pix_out   <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            frame_err <= acc && in_sof && started && (col != '0 || row != '0);
            if (acc) begin
                started <= 1'b1;
                col     <= c_eff == CMAX ? '0 : c_eff + CW'(1);
                row     <= c_eff == CMAX ? (r_eff == RMAX ? '0 : r_eff + RW'(1)) : r_eff;
                if (prime_cnt != PRIME)
                    prime_cnt <= prime_cnt + (CW + 1)'(1);
            end
            v1        <= trig;
            sof1      <= trig && cr == '0 && cc == '0;
            pass1     <= pass;
            out_valid <= v1;
            out_sof   <= sof1;
            if (v1)
                pix_out <= pass1 ? w[1][1] : filt;
        end
    end
endmodule

// File: tb/tb_kernel_filter_3x3.sv
// tb_kernel_filter_3x3: directed frames on an 8x6 image with a cycle-level valid/sof/err reference.
module tb_kernel_filter_3x3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    typedef struct {
        int pat;
        int r;
        int c;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] pix_in = '0;
    logic in_valid = 1'b0, in_sof = 1'b0;
    logic [7:0] pix_out;
    logic out_valid, out_sof, frame_err;

    always #5 clk = ~clk;

    kernel_filter_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .in_valid(in_valid), .in_sof(in_sof),
        .pix_out(pix_out), .out_valid(out_valid), .out_sof(out_sof), .frame_err(frame_err)
    );

    int nvec = 0, nerr = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference: linear pixel index, priming count, 2-cycle output delay
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    bit started_m, ev0, ev1, es0, es1, ee;
    int cnt_m, pos_m, ei0, ei1, m_p, m_ci;
    logic m_acc, m_trig;
    assign m_acc  = in_valid && (started_m || in_sof);
    assign m_p    = in_sof ? 0 : pos_m;
    assign m_trig = m_acc && cnt_m >= W + 1;
    assign m_ci   = (m_p + N - (W + 1)) % N;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            started_m <= 0; cnt_m <= 0; pos_m <= 0;
            ev0 <= 0; ev1 <= 0; es0 <= 0; es1 <= 0; ee <= 0; ei0 <= 0; ei1 <= 0;
        end else begin
            ee  <= m_acc && in_sof && started_m && pos_m != 0;
            ev0 <= m_trig; ev1 <= ev0;
            es0 <= m_trig && m_ci == 0; es1 <= es0;
            ei0 <= m_ci; ei1 <= ei0;
            if (m_acc) begin
                started_m <= 1;
                pos_m <= (m_p + 1) % N;
                if (cnt_m < W + 1) cnt_m <= cnt_m + 1;
            end
        end
    end

    int slot = 0, nvalid = 0, nfe = 0, err_cyc = 0, osof_cyc = 0;
    int nout [6];
    logic first_sof [6];
    logic [7:0] img [6][N];
    always @(negedge clk) begin
        chk("out_valid", out_valid, ev1);
        chk("out_sof", out_sof, es1);
        chk("frame_err", frame_err, ee);
        if (out_valid) begin
            nvalid++;
            if (nout[slot] == 0) first_sof[slot] = out_sof;
            nout[slot]++;
            if (ev1) img[slot][ei1] = pix_out;
        end
        if (out_sof) osof_cyc = cyc;
        if (frame_err) begin
            nfe++;
            err_cyc = cyc;
        end
    end

    vec_t tbl [20];

    function automatic logic [7:0] pixel(input int pat, input int r, input int c);
        return pat == 0 ? 8'h80 : pat == 1 ? ((r == 2 && c == 3) ? 8'hff : 8'h00) : 8'(c * 16);
    endfunction

    function automatic logic [7:0] exp_pix(input int pat, input int r, input int c);
        logic [7:0] e = pat == 0 ? 8'h80 : pat == 2 ? 8'(c * 16) : 8'h00;
        for (int i = 0; i < 20; i++)
            if (pat == 1 && tbl[i].pat == 1 && tbl[i].r == r && tbl[i].c == c) e = tbl[i].exp;
        return e;
    endfunction

    task automatic drive(input logic [7:0] p, input logic v, input logic s);
        @(posedge clk);
        #1;
        pix_in = p; in_valid = v; in_sof = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int s, input bit gap);
        slot = s;
        do_reset();
        for (int i = 0; i < N + W + 1; i++) begin
            drive(pixel(pat, (i % N) / W, i % W), 1'b1, (i % N) == 0);
            if (gap) drive(8'h5a, 1'b0, 1'b1);
        end
        idle(4);
        chk("n_out", nout[s], N);
        chk("first_sof", first_sof[s], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int sc;
        tbl[0]  = '{1, 1, 2, 8'h10}; tbl[1]  = '{1, 1, 3, 8'h20}; tbl[2]  = '{1, 1, 4, 8'h10};
        tbl[3]  = '{1, 2, 2, 8'h20}; tbl[4]  = '{1, 2, 3, 8'h40}; tbl[5]  = '{1, 2, 4, 8'h20};
        tbl[6]  = '{1, 3, 2, 8'h10}; tbl[7]  = '{1, 3, 3, 8'h20}; tbl[8]  = '{1, 3, 4, 8'h10};
        tbl[9]  = '{0, 0, 0, 8'h80}; tbl[10] = '{0, 3, 4, 8'h80}; tbl[11] = '{0, 5, 7, 8'h80};
        tbl[12] = '{2, 0, 0, 8'h00}; tbl[13] = '{2, 2, 0, 8'h00}; tbl[14] = '{2, 3, 7, 8'h70};
        tbl[15] = '{2, 2, 3, 8'h30}; tbl[16] = '{2, 4, 6, 8'h60}; tbl[17] = '{2, 5, 5, 8'h50};
        tbl[18] = '{1, 1, 1, 8'h00}; tbl[19] = '{1, 4, 3, 8'h00};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_pix_out", pix_out, 0);
        chk("reset_out_valid", out_valid, 0);

        run_frame(0, 0, 1'b0);
        run_frame(1, 1, 1'b0);
        run_frame(2, 2, 1'b0);
        run_frame(1, 3, 1'b1);

        for (int i = 0; i < 20; i++) begin
            chk($sformatf("tbl%0d", i), img[tbl[i].pat][tbl[i].r * W + tbl[i].c], tbl[i].exp);
            if (tbl[i].pat == 1) chk($sformatf("tbl%0d_gap", i), img[3][tbl[i].r * W + tbl[i].c], tbl[i].exp);
        end
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < N; p++)
                chk($sformatf("img%0d_%0d_%0d", s, p / W, p % W), img[s][p], exp_pix(s == 3 ? 1 : s, p / W, p % W));

        // frame start arriving at (2,5)
        slot = 4;
        do_reset();
        nfe = 0;
        for (int i = 0; i < 21; i++) drive(pixel(2, i / W, i % W), 1'b1, i == 0);
        drive(8'h11, 1'b1, 1'b1);
        sc = cyc;
        for (int i = 1; i < W + 2; i++) drive(pixel(2, i / W, i % W), 1'b1, 1'b0);
        idle(4);
        chk("err_pulses", nfe, 1);
        chk("err_latency", err_cyc - sc, 1);
        chk("resync_sof_latency", osof_cyc - sc, W + 3);

        // reset in the middle of a frame
        slot = 5;
        do_reset();
        for (int i = 0; i < 31; i++) drive(pixel(2, i / W, i % W), 1'b1, i == 0);
        #2;
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("mid_reset_pix_out", pix_out, 0);
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_out_sof", out_sof, 0);
        chk("mid_reset_frame_err", frame_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 10; i++) drive(8'h33, 1'b1, 1'b0);
        for (int i = 0; i < W + 1; i++) drive(pixel(2, 0, i % W), 1'b1, i == 0);
        idle(4);
        chk("primed_no_valid", nvalid, 0);
        drive(8'h44, 1'b1, 1'b0);
        idle(4);
        chk("primed_first_valid", nvalid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
